// File: rtl/uvmt_axil_st_prot_chkr.sv
// uvmt_axil_st_prot_chkr: passive AXI-Lite link checker for handshake stability, response ordering, outstanding limits and timeouts
module uvmt_axil_st_prot_chkr #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  input  logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  input  logic                    bready,
  input  logic [1:0]              bresp,
  input  logic                    arvalid,
  input  logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic                    rvalid,
  input  logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  output logic [8:0]              err_flags,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic                    err_pulse,
  output logic [7:0]              wr_outstanding,
  output logic [7:0]              rd_outstanding
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [7:0] MAXO = 8'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);
  logic r_aw_stall, r_w_stall, r_b_stall, r_ar_stall, r_r_stall;
  logic [ADDR_WIDTH+2:0] r_aw_pl, r_ar_pl;
  logic [DATA_WIDTH+SW-1:0] r_w_pl;
  logic [1:0] r_b_pl;
  logic [DATA_WIDTH+1:0] r_r_pl;
  logic [7:0] r_aw_pend, r_w_pend, r_rd_pend;
  logic [TW-1:0] r_wr_wd, r_rd_wd;
  logic [8:0] r_flags;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic r_pulse;
  logic [ADDR_WIDTH+2:0] w_aw_pl, w_ar_pl;
  logic [DATA_WIDTH+SW-1:0] w_w_pl;
  logic [DATA_WIDTH+1:0] w_r_pl;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_b_ok, w_r_ok, w_aw_ovf, w_w_ovf, w_rd_ovf;
  logic [7:0] w_aw_nxt, w_w_nxt, w_rd_nxt, w_wr_out;
  logic w_wr_run, w_rd_run, w_wr_to, w_rd_to;
  logic [TW-1:0] w_wr_wd_nxt, w_rd_wd_nxt;
  logic [8:0] w_new;
  logic [CNT_WIDTH-1:0] w_cnt_base;
  assign w_aw_pl = {awaddr, awprot};
  assign w_ar_pl = {araddr, arprot};
  assign w_w_pl  = {wdata, wstrb};
  assign w_r_pl  = {rdata, rresp};
  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  assign w_b_hs  = bvalid & bready;
  assign w_ar_hs = arvalid & arready;
  assign w_r_hs  = rvalid & rready;
  assign w_b_ok  = w_b_hs & (r_aw_pend != 8'd0) & (r_w_pend != 8'd0);
  assign w_r_ok  = w_r_hs & (r_rd_pend != 8'd0);
  assign w_wr_out = (r_aw_pend < r_w_pend) ? r_aw_pend : r_w_pend;
  always_comb begin
    w_aw_ovf = w_aw_hs & ~w_b_ok & (r_aw_pend == MAXO);
    w_w_ovf  = w_w_hs & ~w_b_ok & (r_w_pend == MAXO);
    w_rd_ovf = w_ar_hs & ~w_r_ok & (r_rd_pend == MAXO);
    w_aw_nxt = (w_aw_hs & ~w_b_ok) ? (w_aw_ovf ? r_aw_pend : r_aw_pend + 8'd1) :
               (~w_aw_hs & w_b_ok) ? r_aw_pend - 8'd1 : r_aw_pend;
    w_w_nxt  = (w_w_hs & ~w_b_ok) ? (w_w_ovf ? r_w_pend : r_w_pend + 8'd1) :
               (~w_w_hs & w_b_ok) ? r_w_pend - 8'd1 : r_w_pend;
    w_rd_nxt = (w_ar_hs & ~w_r_ok) ? (w_rd_ovf ? r_rd_pend : r_rd_pend + 8'd1) :
               (~w_ar_hs & w_r_ok) ? r_rd_pend - 8'd1 : r_rd_pend;
    // watchdogs park at the limit so a withheld response reports only once
    w_wr_run = TO_EN & (w_wr_out != 8'd0) & ~w_b_hs;
    w_rd_run = TO_EN & (r_rd_pend != 8'd0) & ~w_r_hs;
    w_wr_to  = w_wr_run & (r_wr_wd == TLIM - TW'(1));
    w_rd_to  = w_rd_run & (r_rd_wd == TLIM - TW'(1));
    w_wr_wd_nxt = ~w_wr_run ? '0 : (r_wr_wd != TLIM) ? r_wr_wd + TW'(1) : r_wr_wd;
    w_rd_wd_nxt = ~w_rd_run ? '0 : (r_rd_wd != TLIM) ? r_rd_wd + TW'(1) : r_rd_wd;
    w_new[0] = r_aw_stall & (~awvalid | (w_aw_pl != r_aw_pl));
    w_new[1] = r_w_stall & (~wvalid | (w_w_pl != r_w_pl));
    w_new[2] = r_b_stall & (~bvalid | (bresp != r_b_pl));
    w_new[3] = r_ar_stall & (~arvalid | (w_ar_pl != r_ar_pl));
    w_new[4] = r_r_stall & (~rvalid | (w_r_pl != r_r_pl));
    w_new[5] = w_b_hs & ~w_b_ok;
    w_new[6] = w_r_hs & ~w_r_ok;
    w_new[7] = w_wr_to | w_rd_to;
    w_new[8] = w_aw_ovf | w_w_ovf | w_rd_ovf;
    w_cnt_base = clr ? '0 : r_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_aw_stall, r_w_stall, r_b_stall, r_ar_stall, r_r_stall} <= '0;
      r_aw_pl   <= '0;
      r_ar_pl   <= '0;
      r_w_pl    <= '0;
      r_b_pl    <= '0;
      r_r_pl    <= '0;
      r_aw_pend <= '0;
      r_w_pend  <= '0;
      r_rd_pend <= '0;
      r_wr_wd   <= '0;
      r_rd_wd   <= '0;
      r_flags   <= '0;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_aw_stall <= awvalid & ~awready;
      r_w_stall  <= wvalid & ~wready;
      r_b_stall  <= bvalid & ~bready;
      r_ar_stall <= arvalid & ~arready;
      r_r_stall  <= rvalid & ~rready;
      r_aw_pl    <= w_aw_pl;
      r_ar_pl    <= w_ar_pl;
      r_w_pl     <= w_w_pl;
      r_b_pl     <= bresp;
      r_r_pl     <= w_r_pl;
      r_aw_pend  <= w_aw_nxt;
      r_w_pend   <= w_w_nxt;
      r_rd_pend  <= w_rd_nxt;
      r_wr_wd    <= w_wr_wd_nxt;
      r_rd_wd    <= w_rd_wd_nxt;
      r_flags    <= (clr ? 9'd0 : r_flags) | w_new;
      r_cnt      <= ((|w_new) && !(&w_cnt_base)) ? w_cnt_base + CNT_WIDTH'(1) : w_cnt_base;
      r_pulse    <= |w_new;
    end
  end
  assign err_flags      = r_flags;
  assign err_count      = r_cnt;
  assign err_pulse      = r_pulse;
  assign wr_outstanding = w_wr_out;
  assign rd_outstanding = r_rd_pend;
endmodule

// File: tb/tb_uvmt_axil_st_prot_chkr.sv
// tb_uvmt_axil_st_prot_chkr: directed scenarios with hand-computed expectations for the AXI-Lite checker
module tb_uvmt_axil_st_prot_chkr;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0;
  logic awvalid = 0, awready = 0, wvalid = 0, wready = 0, bvalid = 0, bready = 0;
  logic arvalid = 0, arready = 0, rvalid = 0, rready = 0;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic [8:0] err_flags;
  logic [15:0] err_count;
  logic err_pulse;
  logic [7:0] wr_outstanding, rd_outstanding;
  int checks = 0, errors = 0;
  uvmt_axil_st_prot_chkr #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .err_flags(err_flags), .err_count(err_count), .err_pulse(err_pulse),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready} = '0;
    clr = 1'b0;
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== '0) begin
      errors++;
      $display("FAIL reset_outputs flags=%h count=%0d pulse=%b wr=%0d rd=%0d, all required 0", err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding);
    end
  endtask
  task automatic test_clean();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      awaddr = 32'h40 + 32'(i * 4); wdata = 32'hA0 + 32'(i); wstrb = 4'hF;
      {awvalid, awready, wvalid, wready} = 4'hF;
      tick();
      idle();
      checks++;
      if (wr_outstanding !== 8'd1) begin errors++; $display("FAIL clean_wr_pending got %0d exp 1", wr_outstanding); end
      tick();
      tick();
      {bvalid, bready} = 2'b11;
      tick();
      idle();
    end
    for (int i = 0; i < 4; i++) begin
      araddr = 32'h80 + 32'(i * 4);
      {arvalid, arready} = 2'b11;
      tick();
      idle();
      checks++;
      if (rd_outstanding !== 8'd1) begin errors++; $display("FAIL clean_rd_pending got %0d exp 1", rd_outstanding); end
      tick();
      tick();
      rdata = 32'h55 + 32'(i);
      {rvalid, rready} = 2'b11;
      tick();
      idle();
    end
    checks++;
    if ({err_flags, err_count, wr_outstanding, rd_outstanding} !== '0) begin
      errors++;
      $display("FAIL clean_end flags=%h count=%0d wr=%0d rd=%0d, all required 0", err_flags, err_count, wr_outstanding, rd_outstanding);
    end
  endtask
  task automatic test_stall();
    do_reset();
    awaddr = 32'h100; awvalid = 1'b1;
    tick();
    checks++;
    if (err_flags !== 9'h000) begin errors++; $display("FAIL stall_first flags got %h exp 000", err_flags); end
    awaddr = 32'h104;
    tick();
    checks++;
    if (err_flags !== 9'h001 || err_pulse !== 1'b1 || err_count !== 16'd1) begin
      errors++; $display("FAIL aw_stable flags=%h pulse=%b count=%0d exp 001/1/1", err_flags, err_pulse, err_count);
    end
    awready = 1'b1;
    tick();
    idle();
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 16'd1) begin
      errors++; $display("FAIL aw_pulse_width pulse=%b count=%0d exp 0/1", err_pulse, err_count);
    end
    rdata = 32'h5; rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    tick();
    checks++;
    if (err_flags !== 9'h011 || err_count !== 16'd2) begin
      errors++; $display("FAIL r_stable flags=%h count=%0d exp 011/2", err_flags, err_count);
    end
  endtask
  task automatic test_orphan();
    do_reset();
    {bvalid, bready} = 2'b11;
    tick();
    idle();
    checks++;
    if (err_flags !== 9'h020 || err_count !== 16'd1) begin
      errors++; $display("FAIL orphan_b flags=%h count=%0d exp 020/1", err_flags, err_count);
    end
    {arvalid, arready, rvalid, rready} = 4'hF;
    tick();
    idle();
    checks++;
    if (err_flags !== 9'h060 || err_count !== 16'd2 || rd_outstanding !== 8'd1) begin
      errors++; $display("FAIL same_cycle_r flags=%h count=%0d rd=%0d exp 060/2/1", err_flags, err_count, rd_outstanding);
    end
    do_reset();
    {bvalid, bready, rvalid, rready} = 4'hF;
    tick();
    idle();
    checks++;
    if (err_flags !== 9'h060 || err_count !== 16'd1 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL dual_orphan flags=%h count=%0d pulse=%b exp 060/1/1", err_flags, err_count, err_pulse);
    end
  endtask
  task automatic test_overflow();
    do_reset();
    {arvalid, arready} = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (err_flags !== 9'h000 || rd_outstanding !== 8'd4) begin
      errors++; $display("FAIL pre_overflow flags=%h rd=%0d exp 000/4", err_flags, rd_outstanding);
    end
    tick();
    idle();
    checks++;
    if (err_flags !== 9'h100 || rd_outstanding !== 8'd4 || err_count !== 16'd1) begin
      errors++; $display("FAIL overflow flags=%h rd=%0d count=%0d exp 100/4/1", err_flags, rd_outstanding, err_count);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    {awvalid, awready, wvalid, wready} = 4'hF;
    tick();
    idle();
    checks++;
    if (wr_outstanding !== 8'd1) begin errors++; $display("FAIL to_pending got %0d exp 1", wr_outstanding); end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (err_flags !== 9'h000) begin errors++; $display("FAIL to_early flags got %h exp 000", err_flags); end
    tick();
    checks++;
    if (err_flags !== 9'h080 || err_pulse !== 1'b1 || err_count !== 16'd1) begin
      errors++; $display("FAIL timeout flags=%h pulse=%b count=%0d exp 080/1/1", err_flags, err_pulse, err_count);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (err_count !== 16'd1 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL to_once count=%0d pulse=%b exp 1/0", err_count, err_pulse);
    end
    {bvalid, bready} = 2'b11;
    tick();
    idle();
    checks++;
    if (wr_outstanding !== 8'd0 || err_count !== 16'd1) begin
      errors++; $display("FAIL to_b_done wr=%0d count=%0d exp 0/1", wr_outstanding, err_count);
    end
    {awvalid, awready, wvalid, wready} = 4'hF;
    tick();
    idle();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (err_count !== 16'd1) begin errors++; $display("FAIL to_rearm_early count got %0d exp 1", err_count); end
    tick();
    checks++;
    if (err_count !== 16'd2) begin errors++; $display("FAIL to_rearm count got %0d exp 2", err_count); end
  endtask
  task automatic test_clr_reset();
    do_reset();
    {bvalid, bready} = 2'b11;
    wdata = 32'hAAAA; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    checks++;
    if (err_flags !== 9'h020 || err_count !== 16'd1) begin
      errors++; $display("FAIL clr_pre flags=%h count=%0d exp 020/1", err_flags, err_count);
    end
    {bvalid, bready} = 2'b00;
    wdata = 32'hBBBB; clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (err_flags !== 9'h002 || err_count !== 16'd1 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL clr_with_err flags=%h count=%0d pulse=%b exp 002/1/1", err_flags, err_count, err_pulse);
    end
    wready = 1'b1;
    tick();
    idle();
    do_reset();
    {arvalid, arready, bvalid, bready} = 4'hF;
    tick();
    {bvalid, bready} = 2'b00;
    tick();
    idle();
    checks++;
    if (rd_outstanding !== 8'd2 || err_flags !== 9'h020) begin
      errors++; $display("FAIL rst_pre rd=%0d flags=%h exp 2/020", rd_outstanding, err_flags);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding} !== '0) begin
      errors++; $display("FAIL rst_mid flags=%h count=%0d pulse=%b wr=%0d rd=%0d, all required 0", err_flags, err_count, err_pulse, wr_outstanding, rd_outstanding);
    end
    {rvalid, rready} = 2'b11;
    tick();
    idle();
    checks++;
    if (err_flags !== 9'h040 || err_count !== 16'd1 || rd_outstanding !== 8'd0) begin
      errors++; $display("FAIL rst_late_r flags=%h count=%0d rd=%0d exp 040/1/0", err_flags, err_count, rd_outstanding);
    end
  endtask
  initial begin
    test_reset();
    test_clean();
    test_stall();
    test_orphan();
    test_overflow();
    test_timeout();
    test_clr_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
